// File: rtl/pwm_velocity_decoder.sv
// Measures high time and period of each PWM cycle and decodes the high time into a
// 3-bit velocity level. Loss of edges for TIMEOUT clocks reports signal_lost.
module pwm_velocity_decoder #(
    parameter int PERIOD     = 1_000_000,
    parameter int PERIOD_TOL = 10_000,
    parameter int MIN_W      = 30_000,
    parameter int MAX_W      = 115_000,
    parameter int T1         = 40_350,
    parameter int T2         = 51_075,
    parameter int T3         = 61_800,
    parameter int T4         = 72_500,
    parameter int T5         = 83_200,
    parameter int T6         = 93_925,
    parameter int T7         = 104_650,
    parameter int TIMEOUT    = 1_100_000,
    parameter int N          = 21
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pwm,
    output logic [2:0] level,
    output logic       valid,
    output logic       level_changed,
    output logic       signal_lost,
    output logic [1:0] db_state
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StHigh   = 2'b01,
        StLow    = 2'b10,
        StUnused = 2'b11
    } state_t;

    localparam logic [N:0]   PER_MIN = (N+1)'(PERIOD - PERIOD_TOL);
    localparam logic [N:0]   PER_MAX = (N+1)'(PERIOD + PERIOD_TOL);
    localparam logic [N-1:0] W_MIN   = N'(MIN_W);
    localparam logic [N-1:0] W_MAX   = N'(MAX_W);
    localparam logic [N-1:0] THR1    = N'(T1);
    localparam logic [N-1:0] THR2    = N'(T2);
    localparam logic [N-1:0] THR3    = N'(T3);
    localparam logic [N-1:0] THR4    = N'(T4);
    localparam logic [N-1:0] THR5    = N'(T5);
    localparam logic [N-1:0] THR6    = N'(T6);
    localparam logic [N-1:0] THR7    = N'(T7);
    localparam logic [N-1:0] TO_CNT  = N'(TIMEOUT);
    localparam logic [N-1:0] CNT_MAX = '1;

    state_t         state;
    logic           s1, s2, s3;
    logic           rise, fall;
    logic [N-1:0]   cnt;
    logic [N-1:0]   cnt_inc;
    logic [N-1:0]   width_cap;
    logic [N:0]     period;
    logic           legal;
    logic           timeout;
    logic [2:0]     new_level;

    assign db_state = state;

    always_comb begin
        rise    = s2 & ~s3;
        fall    = ~s2 & s3;
        cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + N'(1);
        period  = {1'b0, cnt} + (N+1)'(1);
        timeout = (cnt == TO_CNT);
        legal   = (period >= PER_MIN) && (period <= PER_MAX) &&
                  (width_cap >= W_MIN) && (width_cap <= W_MAX);
        // Thresholds ascend, so the last one met equals the count of thresholds met.
        new_level = 3'd0;
        if (width_cap >= THR1) new_level = 3'd1;
        if (width_cap >= THR2) new_level = 3'd2;
        if (width_cap >= THR3) new_level = 3'd3;
        if (width_cap >= THR4) new_level = 3'd4;
        if (width_cap >= THR5) new_level = 3'd5;
        if (width_cap >= THR6) new_level = 3'd6;
        if (width_cap >= THR7) new_level = 3'd7;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            s3            <= 1'b0;
            state         <= StIdle;
            cnt           <= '0;
            width_cap     <= '0;
            level         <= 3'd0;
            valid         <= 1'b0;
            level_changed <= 1'b0;
            signal_lost   <= 1'b0;
        end else begin
            s1            <= pwm;
            s2            <= s1;
            s3            <= s2;
            level_changed <= 1'b0;
            signal_lost   <= 1'b0;
            case (state)
                StIdle: begin
                    cnt <= '0;
                    if (rise) state <= StHigh;
                end
                StHigh: begin
                    if (timeout) begin
                        state       <= StIdle;
                        cnt         <= '0;
                        valid       <= 1'b0;
                        signal_lost <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                        if (fall) begin
                            width_cap <= cnt_inc;
                            state     <= StLow;
                        end
                    end
                end
                StLow: begin
                    // A rise coinciding with the timeout is discarded.
                    if (timeout) begin
                        state       <= StIdle;
                        cnt         <= '0;
                        valid       <= 1'b0;
                        signal_lost <= 1'b1;
                    end else if (rise) begin
                        state <= StHigh;
                        cnt   <= '0;
                        if (legal) begin
                            level         <= new_level;
                            valid         <= 1'b1;
                            level_changed <= (new_level != level) || !valid;
                        end else begin
                            valid <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= StIdle;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/pwm_velocity_decoder.md
Name: pwm_velocity_decoder

Overview:
- Receives the velocimeter PWM waveform (1,000,000-clock period, eight high-time widths for velocity levels 0..7).
- Measures the high time and the period of each cycle, validates them, and decodes the result back to a 3-bit velocity level.
- Sits on the gauge/telemetry side of the delivery game. It checks the displayed speed against the combined base + player velocity and drives the debug display.

Parameters:
- PERIOD, 1_000_000: nominal PWM period in clocks.
- PERIOD_TOL, 10_000: allowed ± deviation of the measured period.
- MIN_W, 30_000: minimum legal high time.
- MAX_W, 115_000: maximum legal high time.
- T1..T7, 40_350 / 51_075 / 61_800 / 72_500 / 83_200 / 93_925 / 104_650: decode thresholds, the midpoints between adjacent nominal widths.
- TIMEOUT, 1_100_000: clocks without an expected edge before the signal is declared lost.
- N, 21: counter width; must satisfy 2^N > TIMEOUT.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- pwm, input, 1: raw PWM input, asynchronous to clock.
- level, output, 3: last validly decoded velocity level.
- valid, output, 1: 1 while the most recent measured cycle was legal.
- level_changed, output, 1: one-clock pulse on a valid decode that differs from the previous level, or on a 0→1 transition of valid.
- signal_lost, output, 1: one-clock pulse on timeout.
- db_state, output, 2: FSM state for debug.

Behaviour:
- Reset (async, active-high):
  - level=0, valid=0, level_changed=0, signal_lost=0.
  - FSM=IDLE; counters and synchroniser flops cleared.
- Input synchronisation:
  - pwm passes through 2 flops (s1, s2) plus a history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- Counters:
  - cnt increments every clock in HIGH and LOW, saturating at all-ones.
  - width_cap is an N-bit register loaded from cnt+1 on fall in HIGH.
  - Period = cnt+1 at the rise that ends LOW.
- FSM states, encoded in db_state:
  - IDLE (00): cnt=0. On rise → HIGH with cnt=0. This first rise is not decoded.
  - HIGH (01): on fall, capture width_cap and → LOW (cnt keeps counting from the rise). If cnt reaches TIMEOUT → IDLE, valid=0, signal_lost pulse.
  - LOW (10): on rise:
    - Evaluate period = cnt+1 and width = width_cap.
    - Legal iff |period−PERIOD| ≤ PERIOD_TOL and MIN_W ≤ width ≤ MAX_W.
    - If legal: level = count of thresholds Tk with width ≥ Tk (width<T1 →0, width≥T7 →7); valid=1.
    - If illegal: valid=0 and level holds.
    - Then cnt=0 and stay in a new HIGH measurement (→ HIGH).
    - If cnt reaches TIMEOUT → IDLE, valid=0, signal_lost pulse.
  - 11: unused; recovers to IDLE.
- Latency: level, valid and level_changed update on the 3rd rising clock edge after the raw pwm rise that closes a period.
- Simultaneous events: a rise and a timeout in the same cycle are resolved in favour of the timeout; the cycle is discarded.
- level_changed:
  - Asserts only in the decode cycle, and only when the new valid level ≠ old level or valid goes 0→1.
  - Never asserts on illegal cycles or on timeout.
- Glitches: any rise seen in HIGH or fall seen in LOW is impossible after synchronisation; no special handling is needed.
- Mid-operation reset: all state is cleared immediately. The next rise after reset release is treated as a first rise (no decode).
- Constant pwm:
  - Stuck at 0 or 1 → signal_lost after TIMEOUT clocks.
  - Stays in IDLE with no further pulses until a new rise.

Test Plan:
- Reset, then 3 PWM cycles of period 1_000_000 with high time 35_000 → no decode after the 1st rise; after the 2nd rise level=0, valid=1, level_changed pulses once; the 3rd cycle gives no pulse.
- Cycles at widths 56_450 then 110_000 → level=2 then level=7, each with one level_changed pulse, 3 clocks after the respective closing rise.
- Width 40_349 vs 40_350 (threshold T1) → level=0 vs level=1; width 29_999 → valid=0, level holds.
- Period 1_010_001 with width 67_150 → valid=0, no level_changed; next cycle with period 1_000_000 → level=3, valid=1, level_changed pulse.
- pwm held high for 1_200_000 clocks → signal_lost pulses once at TIMEOUT, valid=0, db_state=00; the following normal cycle is not decoded until the 2nd rise.
- Assert reset during LOW, release, then apply 2 normal cycles of width 77_850 → outputs 0 during reset; level=4, valid=1 after the 2nd post-reset rise.
